// File: rtl/swarb_rr.sv
// swarb_rr: per-output-port switch arbiter for the wormhole router.
// Round-robin pick among five input controllers. The winner holds the port
// from head flit through tail flit. Reports lock status and a saturating
// stall counter.
module swarb_rr #(
    parameter int ROUTERID = 0,
    parameter int PORTID   = 0,
    parameter int NREQ     = 5
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] tail,
    input  logic            ordy,
    output logic [NREQ-1:0] grt,
    output logic [2:0]      owner,
    output logic            busy,
    output logic [7:0]      stall_cnt
);

    // The index arithmetic below is written for exactly five requesters.
    // The ids only tag the instance, so they are just range-checked here.
    if (NREQ != 5) begin : g_bad_nreq
        $error("swarb_rr: NREQ must be 5");
    end
    if (ROUTERID < 0 || PORTID < 0 || PORTID > 4) begin : g_bad_id
        $error("swarb_rr: ROUTERID/PORTID out of range");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state, state_nx;
    logic [2:0]      ptr, ptr_nx;
    logic [2:0]      own, own_nx;
    logic [7:0]      stall_nx;
    logic [2:0]      start;
    logic [2:0]      pick;
    logic            found;
    logic [NREQ-1:0] own_oh;
    logic            xfer;
    logic            own_tail;

    // Unreachable pointer values fall back to 0.
    assign start = (ptr > 3'd4) ? 3'd0 : ptr;

    // Decode the locked owner to a one-hot mask.
    always_comb begin
        own_oh = '0;
        for (int i = 0; i < NREQ; i++)
            if (own == 3'(i)) own_oh[i] = 1'b1;
    end

    // Round-robin search: first requester at start, start+1, ... (mod 5).
    always_comb begin
        logic [3:0] sum;
        logic [2:0] idx;
        pick  = start;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, start} + 4'(k);
            idx = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // A flit moves only while locked, ordy is up and the owner is offering.
    assign xfer     = |(grt & req);
    assign own_tail = |(own_oh & tail);

    // State register: lock is dropped immediately on reset.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            own       <= 3'd0;
            stall_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            own       <= own_nx;
            stall_cnt <= stall_nx;
        end
    end

    // Next-state: arbitrate in IDLE, hold the owner in LOCK until its tail moves.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        own_nx   = own;
        stall_nx = stall_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    own_nx   = pick;
                    state_nx = LOCK;
                end
            end
            LOCK: begin
                if (xfer) begin
                    stall_nx = 8'd0;
                    if (own_tail) begin
                        state_nx = IDLE;
                        ptr_nx   = (own == 3'd4) ? 3'd0 : own + 3'd1;
                    end
                end else if (stall_cnt != 8'hFF) begin
                    stall_nx = stall_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: grant follows ordy combinationally while locked.
    always_comb begin
        grt   = (state == LOCK && ordy) ? own_oh : '0;
        owner = own;
        busy  = (state == LOCK);
    end

endmodule

// File: tb/tb_swarb_rr.sv
// Testbench for swarb_rr: a table of per-cycle vectors plus hand-written
// multi-cycle sequences (round robin, lock hold, backpressure, async reset).
module tb_swarb_rr;

    logic       clk = 1'b0;
    logic       rst_;
    logic [4:0] req;
    logic [4:0] tail;
    logic       ordy;
    logic [4:0] grt;
    logic [2:0] owner;
    logic       busy;
    logic [7:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    swarb_rr #(.ROUTERID(0), .PORTID(0), .NREQ(5)) dut (
        .clk(clk), .rst_(rst_), .req(req), .tail(tail), .ordy(ordy),
        .grt(grt), .owner(owner), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] tail;
        logic       ordy;
        logic [4:0] grt;
        logic [2:0] own;
        logic       busy;
        logic [7:0] stall;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] eg, input logic [2:0] eo,
                              input logic eb, input logic [7:0] es);
        chk({tag, ".grt"}, 32'(grt), 32'(eg));
        chk({tag, ".owner"}, 32'(owner), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".stall"}, 32'(stall_cnt), 32'(es));
    endtask

    // One cycle: drive just after a rising edge, compare mid-cycle, then
    // advance past the next rising edge.
    task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic od,
                        input logic [4:0] eg, input logic [2:0] eo, input logic eb,
                        input logic [7:0] es, input string tag);
        rst_ = r; req = rq; tail = tl; ordy = od;
        #2;
        check_outs(tag, eg, eo, eb, es);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b1; req = '0; tail = '0; ordy = 1'b0;

        //          rst  req       tail      ordy  grt       own   busy  stall
        vt.push_back('{1'b1, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 8'd0}); // reset
        vt.push_back('{1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00000, 3'd0, 1'b0, 8'd0}); // idle, pick 0
        vt.push_back('{1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 8'd0}); // headtail
        vt.push_back('{1'b0, 5'b00011, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 8'd0}); // bubble, ptr=1 picks 1
        vt.push_back('{1'b0, 5'b00011, 5'b00010, 1'b0, 5'b00000, 3'd1, 1'b1, 8'd0}); // ordy low
        vt.push_back('{1'b0, 5'b00011, 5'b00010, 1'b1, 5'b00010, 3'd1, 1'b1, 8'd1}); // tail moves
        vt.push_back('{1'b0, 5'b01000, 5'b01000, 1'b1, 5'b00000, 3'd1, 1'b0, 8'd0}); // idle, owner held
        vt.push_back('{1'b0, 5'b01000, 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b1, 8'd0}); // 3 done -> ptr 4
        vt.push_back('{1'b0, 5'b10001, 5'b00000, 1'b1, 5'b00000, 3'd3, 1'b0, 8'd0}); // pick 4 first
        vt.push_back('{1'b0, 5'b10001, 5'b10000, 1'b1, 5'b10000, 3'd4, 1'b1, 8'd0}); // 4 done -> ptr 0
        vt.push_back('{1'b0, 5'b10001, 5'b00000, 1'b1, 5'b00000, 3'd4, 1'b0, 8'd0}); // pick 0
        vt.push_back('{1'b0, 5'b10001, 5'b00001, 1'b1, 5'b00001, 3'd0, 1'b1, 8'd0}); // 0 done -> ptr 1
        vt.push_back('{1'b0, 5'b10001, 5'b00000, 1'b1, 5'b00000, 3'd0, 1'b0, 8'd0}); // search 1..4 -> 4
        vt.push_back('{1'b0, 5'b10001, 5'b10000, 1'b1, 5'b10000, 3'd4, 1'b1, 8'd0}); // 4 done
        vt.push_back('{1'b0, 5'b00000, 5'b11111, 1'b1, 5'b00000, 3'd4, 1'b0, 8'd0}); // tail w/o req
        vt.push_back('{1'b0, 5'b00000, 5'b00000, 1'b1, 5'b00000, 3'd4, 1'b0, 8'd0}); // still idle

        @(posedge clk);
        #1;
        foreach (vt[i])
            step(vt[i].rst, vt[i].req, vt[i].tail, vt[i].ordy,
                 vt[i].grt, vt[i].own, vt[i].busy, vt[i].stall, $sformatf("vec%0d", i));

        // Round robin: all requesting, 3-flit packets, owners 0,1,2,3,4,0.
        step(1, 5'b00000, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "rr.rst");
        for (int p = 0; p < 6; p++) begin
            int o;
            o = p % 5;
            step(0, 5'b11111, 5'b00000, 1, 5'b00000, (p == 0) ? 3'd0 : 3'((p - 1) % 5), 0, 8'd0,
                 $sformatf("rr.bub%0d", p));
            for (int f = 0; f < 3; f++)
                step(0, 5'b11111, (f == 2) ? 5'(1 << o) : 5'b00000, 1,
                     5'(1 << o), 3'(o), 1, 8'd0, $sformatf("rr.p%0d.f%0d", p, f));
        end

        // Lock hold: owner 2 drops req mid-packet while 0 keeps asking.
        step(1, 5'b00000, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "lk.rst");
        step(0, 5'b00100, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "lk.arb");
        step(0, 5'b00101, 5'b00000, 1, 5'b00100, 3'd2, 1, 8'd0, "lk.head");
        for (int c = 0; c < 5; c++)
            step(0, 5'b00001, 5'b00000, 1, 5'b00100, 3'd2, 1, 8'(c), $sformatf("lk.hold%0d", c));
        step(0, 5'b00101, 5'b00000, 1, 5'b00100, 3'd2, 1, 8'd5, "lk.resume");
        step(0, 5'b00101, 5'b00100, 1, 5'b00100, 3'd2, 1, 8'd0, "lk.tail");
        step(0, 5'b00001, 5'b00000, 1, 5'b00000, 3'd2, 0, 8'd0, "lk.bub");
        step(0, 5'b00001, 5'b00001, 1, 5'b00001, 3'd0, 1, 8'd0, "lk.next0");

        // Backpressure: 300 cycles of ordy low, counter saturates at 255.
        step(1, 5'b00000, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "bp.rst");
        step(0, 5'b00010, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "bp.arb");
        for (int c = 0; c < 300; c++)
            step(0, 5'b00010, 5'b00000, 0, 5'b00000, 3'd1, 1, (c < 255) ? 8'(c) : 8'd255,
                 $sformatf("bp.stall%0d", c));
        step(0, 5'b00010, 5'b00000, 1, 5'b00010, 3'd1, 1, 8'd255, "bp.go");
        step(0, 5'b00010, 5'b00010, 1, 5'b00010, 3'd1, 1, 8'd0, "bp.clr");
        step(0, 5'b00000, 5'b00000, 1, 5'b00000, 3'd1, 0, 8'd0, "bp.idle");

        // Async reset mid-packet: bring ptr to 4, lock owner 3 again, reset.
        step(1, 5'b00000, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "ar.rst");
        step(0, 5'b01000, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "ar.arb1");
        step(0, 5'b01000, 5'b01000, 1, 5'b01000, 3'd3, 1, 8'd0, "ar.pkt1");
        step(0, 5'b01000, 5'b00000, 1, 5'b00000, 3'd3, 0, 8'd0, "ar.arb2");
        step(0, 5'b01000, 5'b00000, 1, 5'b01000, 3'd3, 1, 8'd0, "ar.head");
        step(0, 5'b01000, 5'b00000, 0, 5'b00000, 3'd3, 1, 8'd0, "ar.stall");
        rst_ = 1'b1;
        #1;
        check_outs("ar.async", 5'b00000, 3'd0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        // From ptr=0, requester 3 beats 4; a stale ptr of 4 would pick 4.
        step(0, 5'b11000, 5'b00000, 1, 5'b00000, 3'd0, 0, 8'd0, "ar.arb3");
        step(0, 5'b11000, 5'b01000, 1, 5'b01000, 3'd3, 1, 8'd0, "ar.grant");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
